// File: rtl/hazard_scoreboard_if.sv
// Decode/issue and writeback/scoreboard signals of hazard_scoreboard.
interface hazard_scoreboard_if;
  logic        id_valid;
  logic [5:0]  id_src_a;
  logic [5:0]  id_src_b;
  logic        id_use_a;
  logic        id_use_b;
  logic [5:0]  id_dest;
  logic        id_we;
  logic [1:0]  id_class;
  logic        ex_redirect;
  logic        issue;
  logic        stall_if;
  logic        stall_id;
  logic        flush_id;
  logic        wb_valid;
  logic [5:0]  wb_dest;
  logic        fpu_busy;
  logic [63:0] pending;

  modport master (
    output id_valid, id_src_a, id_src_b, id_use_a, id_use_b,
           id_dest, id_we, id_class, ex_redirect,
    input  issue, stall_if, stall_id, flush_id,
           wb_valid, wb_dest, fpu_busy, pending
  );

  modport slave (
    input  id_valid, id_src_a, id_src_b, id_use_a, id_use_b,
           id_dest, id_we, id_class, ex_redirect,
    output issue, stall_if, stall_id, flush_id,
           wb_valid, wb_dest, fpu_busy, pending
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: issue controller with pending-write scoreboard,
// single write-port slot line and non-pipelined FPU occupancy.
// Optional feature macro: HAZARD_BYPASS_EN (RAW on a slot-1 producer is ready).
module hazard_scoreboard #(
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned FPU_LAT  = 4
) (
  input logic                clk,
  input logic                reset,
  hazard_scoreboard_if.slave bus
);
  localparam int unsigned MAXL = FPU_LAT;

`ifdef HAZARD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic [1:0] {
    CL_ALU  = 2'b00,
    CL_LOAD = 2'b01,
    CL_FPU  = 2'b10,
    CL_JUMP = 2'b11
  } iclass_e;

  logic [63:0]     pending_q, pending_d;
  logic [MAXL-1:0] slot_v_q, slot_v_d;
  logic [5:0]      slot_d_q [MAXL];
  logic [5:0]      slot_d_d [MAXL];
  logic [2:0]      fpu_cnt_q, fpu_cnt_d;

  iclass_e    cls;
  logic [2:0] lat;
  logic [7:0] slot_v_pad;
  logic       we_eff, byp_a, byp_b, raw_a, raw_b, waw, port_hit, fpu_hit;
  logic       hazard, issue;

  assign cls        = iclass_e'(bus.id_class);
  assign slot_v_pad = 8'(slot_v_q);

  // Writeback latency of the instruction in decode.
  always_comb begin
    case (cls)
      CL_LOAD: lat = 3'(LOAD_LAT);
      CL_FPU:  lat = 3'(FPU_LAT);
      default: lat = 3'd1;
    endcase
  end

  // r0 is hardwired: a write to it is dropped from the scoreboard entirely.
  assign we_eff   = bus.id_we && (bus.id_dest != '0);
  assign byp_a    = BYPASS && slot_v_q[0] && (slot_d_q[0] == bus.id_src_a);
  assign byp_b    = BYPASS && slot_v_q[0] && (slot_d_q[0] == bus.id_src_b);
  assign raw_a    = bus.id_use_a && (bus.id_src_a != '0) && pending_q[bus.id_src_a] && !byp_a;
  assign raw_b    = bus.id_use_b && (bus.id_src_b != '0) && pending_q[bus.id_src_b] && !byp_b;
  assign waw      = we_eff && pending_q[bus.id_dest];
  // Slot L+1 shifts into slot L at this edge; padding makes L = MAXL read as free.
  assign port_hit = we_eff && (lat < 3'(MAXL)) && slot_v_pad[lat];
  assign fpu_hit  = (cls == CL_FPU) && (fpu_cnt_q != '0);
  assign hazard   = raw_a || raw_b || waw || port_hit || fpu_hit;
  assign issue    = bus.id_valid && !bus.ex_redirect && !hazard;

  // Next state: scoreboard set/clear, slot line shift and load, FPU counter.
  always_comb begin
    pending_d = pending_q;
    if (slot_v_q[0]) pending_d[slot_d_q[0]] = 1'b0;
    if (issue && we_eff) pending_d[bus.id_dest] = 1'b1;

    slot_v_d = '0;
    for (int unsigned i = 0; i < MAXL; i++) slot_d_d[i] = '0;
    for (int unsigned i = 0; i + 1 < MAXL; i++) begin
      slot_v_d[i] = slot_v_q[i+1];
      slot_d_d[i] = slot_d_q[i+1];
    end
    for (int unsigned i = 0; i < MAXL; i++) begin
      if (issue && we_eff && (3'(i + 1) == lat)) begin
        slot_v_d[i] = 1'b1;
        slot_d_d[i] = bus.id_dest;
      end
    end

    // The issue cycle is the FPU's first busy cycle, so only FPU_LAT-1 remain.
    if (issue && (cls == CL_FPU)) fpu_cnt_d = 3'(FPU_LAT - 1);
    else if (fpu_cnt_q != '0)     fpu_cnt_d = fpu_cnt_q - 3'd1;
    else                          fpu_cnt_d = '0;
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      slot_v_q  <= '0;
      fpu_cnt_q <= '0;
      for (int unsigned i = 0; i < MAXL; i++) slot_d_q[i] <= '0;
    end else begin
      pending_q <= pending_d;
      slot_v_q  <= slot_v_d;
      fpu_cnt_q <= fpu_cnt_d;
      for (int unsigned i = 0; i < MAXL; i++) slot_d_q[i] <= slot_d_d[i];
    end
  end

  assign bus.issue    = issue;
  assign bus.stall_if = bus.id_valid && !issue && !bus.ex_redirect;
  assign bus.stall_id = bus.id_valid && !issue && !bus.ex_redirect;
  assign bus.flush_id = bus.ex_redirect;
  assign bus.wb_valid = slot_v_q[0];
  assign bus.wb_dest  = slot_d_q[0];
  assign bus.fpu_busy = (fpu_cnt_q != '0);
  assign bus.pending  = pending_q;
endmodule
